// File: rtl/bias2_loader.sv
`default_nettype none
// ============================================================================
// Module  : bias2_loader
// Brief   : Assembles byte pairs (low byte first) into 16-bit bias words and
//           writes DEPTH of them to a register file with a running checksum.
// Rev     : 1.0 - initial release
// ============================================================================
module bias2_loader #(
    parameter int DEPTH = 15,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          busy,
    output logic          done,
    output logic [15:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_last_wa;
    logic [DW-1:0] r_last_wd;
    logic [7:0]    r_lo;
    logic [7:0]    r_hi;
    logic [15:0]   r_sum;
    logic          w_hs;
    logic [DW-1:0] w_word;

    assign w_hs     = in_valid & in_ready;
    assign w_word   = {r_hi, r_lo};

    // Abort must suppress the write and the done pulse in the same cycle,
    // so these are gated combinationally rather than registered a cycle late.
    assign in_ready = (r_state == S_LO) || (r_state == S_HI);
    assign we       = (r_state == S_WR) && !abort;
    assign done     = (r_state == S_DONE) && !abort;
    assign busy     = (r_state != S_IDLE);
    assign wa       = we ? r_addr : r_last_wa;
    assign wd       = we ? w_word : r_last_wd;
    assign checksum = r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_last_wa <= '0;
            r_last_wd <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_sum     <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LO;
                        r_addr  <= '0;
                        r_sum   <= '0;
                    end
                end
                S_LO: begin
                    if (w_hs) begin
                        r_lo    <= in_data;
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (w_hs) begin
                        r_hi    <= in_data;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_sum     <= r_sum + w_word;
                    r_last_wa <= r_addr;
                    r_last_wd <= w_word;
                    if (r_addr == C_LAST_ADDR) begin
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + AW'(1);
                        r_state <= S_LO;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias2_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_bias2_loader
// Brief   : Directed self-checking bench for bias2_loader.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_bias2_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [6:0]  wa;
    logic [15:0] wd;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    bias2_loader #(.DEPTH(15), .AW(7), .DW(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          nw = 0;
    int          bi = 0;
    int          pc = 0;
    bit          hs_pending = 1'b0;
    bit          feeding = 1'b0;
    bit          stall = 1'b0;
    logic [15:0] exp_w [0:14];
    logic [7:0]  bytes [0:29];
    logic [6:0]  lwa [0:63];
    logic [15:0] lwd [0:63];
    logic [15:0] vpat = 16'b1011_0010_1110_0101;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Byte source: a handshake seen at a falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (hs_pending) bi++;
        hs_pending = 1'b0;
        if (feeding && bi < 30) begin
            in_valid   = stall ? vpat[pc % 16] : 1'b1;
            pc++;
            in_data    = bytes[bi];
            hs_pending = in_valid && in_ready;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (we && nw < 64) begin
            lwa[nw] = wa;
            lwd[nw] = wd;
            nw++;
        end
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
    end

    task automatic set_words(input bit all_ones);
        for (int k = 0; k < 15; k++) begin
            exp_w[k]       = all_ones ? 16'hFFFF : 16'(16'h0101 * k);
            bytes[2*k]     = exp_w[k][7:0];
            bytes[2*k + 1] = exp_w[k][15:8];
        end
    endtask

    task automatic begin_load(input bit stl);
        @(negedge clk); #2;
        nw = 0; done_cnt = 0; bi = 0; hs_pending = 1'b0; pc = 0;
        stall = stl; feeding = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int pulse_at);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #2;
            start = (i == pulse_at || i == pulse_at + 7);
            if (done_cnt > 0) seen = 1'b1;
        end
        start = 1'b0;
        feeding = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_words(input string tag, input int n);
        for (int k = 0; k < n; k++)
            check(tag, {9'd0, lwa[k], lwd[k]}, {9'd0, 7'(k), exp_w[k]});
    endtask

    initial begin
        int nw_rst;
        bit hit;
        // reset state
        #12;
        check("rst_we", 32'(we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wa", 32'(wa), 0);
        check("rst_wd", 32'(wd), 0);
        check("rst_checksum", 32'(checksum), 0);
        @(negedge clk); #2; rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // back-to-back full load
        set_words(1'b0);
        begin_load(1'b0);
        wait_done(80, -100);
        check("full_nw", nw, 15);
        check_words("full_word", 15);
        check("full_latency", done_cyc - start_cyc, 46);
        check("full_checksum", 32'(checksum), 32'h6969);
        @(negedge clk); #2;
        check("full_done_cnt", done_cnt, 1);
        check("full_busy_after", 32'(busy), 0);
        check("full_hold_wa", 32'(wa), 32'd14);
        check("full_hold_wd", 32'(wd), 32'h0E0E);

        // stalled stream with start pulsed while busy
        begin_load(1'b1);
        wait_done(200, 10);
        check("stall_nw", nw, 15);
        check_words("stall_word", 15);
        check("stall_checksum", 32'(checksum), 32'h6969);
        check("stall_done_cnt", done_cnt, 1);

        // abort in HI after word 5 low byte
        begin_load(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #2;
            if (bi == 11 && in_ready) hit = 1'b1;
        end
        check("abort_reached", 32'(hit), 1);
        abort = 1'b1;
        @(negedge clk); #2;
        abort = 1'b0;
        feeding = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_nw", nw, 5);
        check("abort_checksum", 32'(checksum), 32'h0A0A);
        check("abort_hold_wa", 32'(wa), 32'd4);
        check("abort_hold_wd", 32'(wd), 32'h0404);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_still_nw", nw, 5);
        begin_load(1'b0);
        wait_done(80, -100);
        check("reload_nw", nw, 15);
        check_words("reload_word", 15);
        check("reload_checksum", 32'(checksum), 32'h6969);

        // reset asserted during WR of word 7
        begin_load(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #2;
            if (we && wa == 7'd7) hit = 1'b1;
        end
        check("rst_wr_reached", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        nw_rst = nw;
        check("midrst_we", 32'(we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_wa", 32'(wa), 0);
        check("midrst_wd", 32'(wd), 0);
        check("midrst_checksum", 32'(checksum), 0);
        @(negedge clk); #2; rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        feeding = 1'b0;
        check("midrst_no_writes", nw, nw_rst);
        check("midrst_idle", 32'(busy), 0);
        check("midrst_no_done", done_cnt, 0);

        // checksum wrap with all-ones words
        set_words(1'b1);
        begin_load(1'b0);
        wait_done(80, -100);
        check("wrap_nw", nw, 15);
        check_words("wrap_word", 15);
        check("wrap_latency", done_cyc - start_cyc, 46);
        check("wrap_checksum", 32'(checksum), 32'hFFF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bias2_loader.md
BIAS2_LOADER -- requirements
Module: bias2_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 15, meaning number of 16-bit bias entries to load.
REQ-002 SHALL have parameter AW, default 7, meaning write-address width.
REQ-003 SHALL have parameter DW, default 16, meaning bias word width; DW SHALL equal 16.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a load of DEPTH words (sampled in IDLE only).
REQ-007 abort  input  1  synchronous cancel of an in-progress load.
REQ-008 in_valid  input  1  byte stream valid.
REQ-009 in_data  input  8  byte stream data; low byte of each word first.
REQ-010 in_ready  output  1  loader can accept a byte.
REQ-011 we  output  1  bias register-file write enable, one-cycle pulse per word.
REQ-012 wa  output  AW  bias register-file write address.
REQ-013 wd  output  DW  bias register-file write data.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse after final word written.
REQ-016 checksum  output  16  running sum of written words, modulo 2^16.

Function
REQ-017 SHALL implement states IDLE, LO, HI, WR, DONE.
REQ-018 IDLE: in_ready=0, we=0; start=1 -> LO, address counter cleared to 0, checksum cleared to 0.
REQ-019 LO: in_ready=1; handshake (in_valid & in_ready) captures in_data as low byte -> HI; otherwise hold.
REQ-020 HI: in_ready=1; handshake captures in_data as high byte -> WR; otherwise hold.
REQ-021 WR: in_ready=0, we=1, wa=address counter, wd={high byte, low byte}; checksum += wd on this edge.
REQ-022 WR exit: address = DEPTH-1 -> DONE; else address increments by 1 -> LO.
REQ-023 DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
REQ-024 Per-word latency: we asserts the cycle after the high-byte handshake; minimum 3 cycles per word, minimum 3*DEPTH+1 cycles from start to done with in_valid held high.
REQ-025 in_valid low in LO/HI stalls without data loss; bytes presented while in_ready=0 SHALL NOT be consumed.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort=1 in any non-IDLE state -> IDLE next edge; no write in that cycle (abort overrides WR, we=0), done not asserted, checksum holds last value.
REQ-028 abort and start together in IDLE: abort wins, remain IDLE.
REQ-029 wa, wd SHALL hold last written values when we=0; address counter SHALL never exceed DEPTH-1.
REQ-030 checksum SHALL wrap modulo 2^16 without saturation or flag.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, address 0, captured bytes 0, wa=0, wd=0, checksum=0, we=0, done=0, busy=0, in_ready=0.
REQ-032 Reset mid-load SHALL discard the partial word; no write issued after release until a new start.

Verification
REQ-033 Full load: start, 30 bytes streamed back-to-back, word k = 0x0100*k + k -> 15 we pulses, wa 0..14, wd matches, done at cycle 46 after start, checksum = sum mod 2^16.
REQ-034 Stall: in_valid toggled randomly during load -> identical writes to REQ-033, no byte skipped or duplicated.
REQ-035 Abort in HI after word 5 low byte -> no sixth write, busy=0 next cycle, done never pulses; new start reloads from wa=0.
REQ-036 start pulsed while busy -> ignored, address sequence unaffected.
REQ-037 rst_n asserted during WR of word 7 -> we drops asynchronously, all outputs zero, no further writes until start.
REQ-038 Checksum wrap: all words 0xFFFF -> checksum = 0xFFF1 at done.
